// File: rtl/xy_location_core.sv
// xy_location_core: Avalon-MM peripheral that times two sensor trip inputs and
// derives X = COUNT1 - COUNT2, SUMSQ = COUNT1^2 + COUNT2^2 and RESULT = isqrt(SUMSQ).
// Optional build macro: XYLOC_GPIO_MIRROR_EN mirrors {RESULT[15:0], X[15:0]}
// onto gpio_outputs while STATUS.done is set.
module xy_location_core #(
    parameter int CNT_W     = 16,
    parameter int SQRT_ITER = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    output logic [31:0] slave_readdata,
    input  logic [31:0] slave_writedata,
    input  logic [3:0]  slave_byteenable,
    input  logic [31:0] gpio_inputs,
    output logic [31:0] gpio_outputs,
    input  logic        tripone,
    input  logic        triptwo
);
    localparam int SQ_W  = 2*CNT_W + 1;
    localparam int RAD_W = 2*SQRT_ITER;
    localparam int REM_W = SQRT_ITER + 3;
    localparam int IT_W  = $clog2(SQRT_ITER);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SQUARE, SQRT, DONE} state_t;

    state_t state_reg, state_next;

    logic                 enable_reg;
    logic                 busy_reg, done_reg;
    logic [CNT_W-1:0]     a_reg, b_reg;
    logic [31:0]          x_reg;
    logic [SQ_W-1:0]      sumsq_reg;
    logic [SQRT_ITER-1:0] result_reg, root_reg;
    logic [RAD_W-1:0]     rad_reg;
    logic [REM_W-1:0]     rem_reg;
    logic [IT_W-1:0]      iter_reg;
    logic [31:0]          samples_reg;
    logic [31:0]          gpio_in_reg;
    logic [31:0]          gpio_out;

    // Bus write decode; CTRL.clear is a single-cycle command, never stored
    logic       wr_ctrl, wr_status, clear_cmd, done_clr, start, last_iter;
    logic [1:0] ovf_clr, trip_in, valid_w, ovf_w;
    logic [CNT_W-1:0] count_w [2];

    assign wr_ctrl   = slave_write && (slave_address == 5'd0) && slave_byteenable[0];
    assign wr_status = slave_write && (slave_address == 5'd1) && slave_byteenable[0];
    assign clear_cmd = wr_ctrl && slave_writedata[1];
    assign done_clr  = wr_status && slave_writedata[0];
    assign ovf_clr   = wr_status ? slave_writedata[5:4] : 2'b00;
    assign trip_in   = {triptwo, tripone};
    assign start     = (state_reg == IDLE) && (&valid_w);
    assign last_iter = (iter_reg == IT_W'(SQRT_ITER - 1));

    // One timing channel per sensor: edge detect, saturating counter, latch and flags
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic             trip_reg, prev_reg, valid_reg, ovf_reg;
            logic [CNT_W-1:0] cnt_reg, count_reg;
            logic             ev;
            assign ev = trip_reg && !prev_reg && enable_reg;

            // Counter runs while enabled; a trip edge latches the interval and restarts it
            always_ff @(posedge clk) begin
                if (reset) begin
                    trip_reg  <= 1'b0;
                    prev_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                    ovf_reg   <= 1'b0;
                    cnt_reg   <= '0;
                    count_reg <= '0;
                end else begin
                    trip_reg <= trip_in[gi];
                    prev_reg <= trip_reg;
                    if (ovf_clr[gi]) ovf_reg <= 1'b0;
                    if (start) valid_reg <= 1'b0;
                    if (clear_cmd) begin
                        cnt_reg   <= '0;
                        valid_reg <= 1'b0;
                    end else if (ev) begin
                        count_reg <= cnt_reg;
                        cnt_reg   <= '0;
                        valid_reg <= 1'b1;
                    end else if (enable_reg && cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        // flag only on reaching saturation so a software clear sticks
                        if (cnt_reg == CNT_MAX - 1'b1) ovf_reg <= 1'b1;
                    end
                end
            end

            assign valid_w[gi] = valid_reg;
            assign ovf_w[gi]   = ovf_reg;
            assign count_w[gi] = count_reg;
        end

        // GPIO_OUT stored per byte so each lane honours its own byteenable
        for (gi = 0; gi < 4; gi++) begin : g_gpio
            logic [7:0] byte_reg;
            always_ff @(posedge clk) begin
                if (reset) byte_reg <= 8'h00;
                else if (slave_write && slave_address == 5'd8 && slave_byteenable[gi])
                    byte_reg <= slave_writedata[8*gi +: 8];
            end
            assign gpio_out[8*gi +: 8] = byte_reg;
        end
    endgenerate

    // Square stage and one restoring square-root step (two radicand bits per cycle)
    logic [2*CNT_W-1:0]   sq_a, sq_b;
    logic [SQ_W-1:0]      sumsq_calc;
    logic [CNT_W:0]       diff;
    logic [REM_W-1:0]     rem_shift, trial, rem_new;
    logic                 rem_ge;
    logic [SQRT_ITER-1:0] root_new;

    assign sq_a       = a_reg * a_reg;
    assign sq_b       = b_reg * b_reg;
    assign sumsq_calc = {1'b0, sq_a} + {1'b0, sq_b};
    assign diff       = {1'b0, a_reg} - {1'b0, b_reg};
    assign rem_shift  = {rem_reg[REM_W-3:0], rad_reg[RAD_W-1 -: 2]};
    assign trial      = {1'b0, root_reg, 2'b01};
    assign rem_ge     = (rem_shift >= trial);
    assign rem_new    = rem_ge ? (rem_shift - trial) : rem_shift;
    assign root_new   = {root_reg[SQRT_ITER-2:0], rem_ge};

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SQUARE;
            SQUARE:  state_next = SQRT;
            SQRT:    if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers; done/busy/SAMPLES update as the last root bit resolves
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            x_reg       <= '0;
            sumsq_reg   <= '0;
            result_reg  <= '0;
            root_reg    <= '0;
            rad_reg     <= '0;
            rem_reg     <= '0;
            iter_reg    <= '0;
            samples_reg <= '0;
        end else begin
            if (clear_cmd || done_clr) done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    a_reg    <= count_w[0];
                    b_reg    <= count_w[1];
                    busy_reg <= 1'b1;
                end
                SQUARE: begin
                    x_reg     <= {{(31-CNT_W){diff[CNT_W]}}, diff};
                    sumsq_reg <= sumsq_calc;
                    rad_reg   <= {{(RAD_W-SQ_W){1'b0}}, sumsq_calc};
                    rem_reg   <= '0;
                    root_reg  <= '0;
                    iter_reg  <= '0;
                end
                SQRT: begin
                    rad_reg  <= {rad_reg[RAD_W-3:0], 2'b00};
                    rem_reg  <= rem_new;
                    root_reg <= root_new;
                    iter_reg <= iter_reg + 1'b1;
                    if (last_iter) begin
                        result_reg  <= root_new;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        samples_reg <= samples_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // CTRL.enable and the sampled GPIO inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_reg  <= 1'b1;
            gpio_in_reg <= '0;
        end else begin
            gpio_in_reg <= gpio_inputs;
            if (wr_ctrl) enable_reg <= slave_writedata[0];
        end
    end

    // Registered read mux; returns 0 whenever no read is presented
    always_ff @(posedge clk) begin
        if (reset) begin
            slave_readdata <= '0;
        end else if (slave_read) begin
            case (slave_address)
                5'd0:    slave_readdata <= {31'b0, enable_reg};
                5'd1:    slave_readdata <= {26'b0, ovf_w, valid_w, busy_reg, done_reg};
                5'd2:    slave_readdata <= {{(32-CNT_W){1'b0}}, count_w[0]};
                5'd3:    slave_readdata <= {{(32-CNT_W){1'b0}}, count_w[1]};
                5'd4:    slave_readdata <= x_reg;
                5'd5:    slave_readdata <= sumsq_reg[31:0];
                5'd6:    slave_readdata <= {31'b0, sumsq_reg[SQ_W-1]};
                5'd7:    slave_readdata <= {{(32-SQRT_ITER){1'b0}}, result_reg};
                5'd8:    slave_readdata <= gpio_out;
                5'd9:    slave_readdata <= gpio_in_reg;
                5'd10:   slave_readdata <= samples_reg;
                default: slave_readdata <= '0;
            endcase
        end else begin
            slave_readdata <= '0;
        end
    end

`ifdef XYLOC_GPIO_MIRROR_EN
    assign gpio_outputs = done_reg ? {result_reg[15:0], x_reg[15:0]} : gpio_out;
`else
    assign gpio_outputs = gpio_out;
`endif

endmodule

// File: tb/tb_xy_location_core.sv
// Scoreboard bench for xy_location_core: expected read data is queued when a
// read is issued and compared when the registered read data returns.
module tb_xy_location_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic        slave_write = 1'b0;
    logic [31:0] slave_readdata;
    logic [31:0] slave_writedata = '0;
    logic [3:0]  slave_byteenable = '0;
    logic [31:0] gpio_inputs = '0;
    logic [31:0] gpio_outputs;
    logic        tripone = 1'b0;
    logic        triptwo = 1'b0;

    xy_location_core dut (
        .clk(clk), .reset(reset),
        .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
        .slave_readdata(slave_readdata), .slave_writedata(slave_writedata),
        .slave_byteenable(slave_byteenable),
        .gpio_inputs(gpio_inputs), .gpio_outputs(gpio_outputs),
        .tripone(tripone), .triptwo(triptwo)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          edge_n = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    longint      m_c1 = 0, m_c2 = 0;
    int          last1 = 0, last2 = 0;
    int          samples_exp = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    function automatic longint isqrt(longint s);
        longint lo = 0, hi = 200000, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= s) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    // One active edge; inputs change and outputs are sampled 1 unit after it
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic wait_until(int n);
        while (edge_n < n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        edge_n = 0;
        last1 = 0;
        last2 = 0;
        samples_exp = 0;
    endtask

    task automatic rd(logic [4:0] addr, logic [31:0] exp, string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        slave_address = addr;
        slave_read = 1'b1;
        tick();
        slave_read = 1'b0;
        check(tag_q.pop_front(), slave_readdata, exp_q.pop_front());
    endtask

    task automatic raw_rd(logic [4:0] addr, output logic [31:0] data);
        slave_address = addr;
        slave_read = 1'b1;
        tick();
        slave_read = 1'b0;
        data = slave_readdata;
    endtask

    task automatic wr(logic [4:0] addr, logic [31:0] data, logic [3:0] be);
        slave_address = addr;
        slave_writedata = data;
        slave_byteenable = be;
        slave_write = 1'b1;
        tick();
        slave_write = 1'b0;
        slave_byteenable = '0;
    endtask

    // Trip input(s) sampled high at edge b; interval = edges since the previous latch
    task automatic trip_at(int b, bit s1, bit s2);
        wait_until(b - 1);
        tripone = s1;
        triptwo = s2;
        tick();
        tripone = 1'b0;
        triptwo = 1'b0;
        if (s1) begin
            m_c1 = (b - last1 > 65535) ? 65535 : b - last1;
            last1 = b + 1;
        end
        if (s2) begin
            m_c2 = (b - last2 > 65535) ? 65535 : b - last2;
            last2 = b + 1;
        end
    endtask

    task automatic wait_done();
        logic [31:0] s;
        int n = 0;
        do begin
            raw_rd(5'd1, s);
            n++;
        end while (!s[0] && n < 60);
        check("done_seen", {31'b0, s[0]}, 32'd1);
        samples_exp++;
    endtask

    task automatic read_results(string t);
        longint      sq = m_c1 * m_c1 + m_c2 * m_c2;
        logic [32:0] sq33 = sq[32:0];
        logic [31:0] xv = 32'(m_c1 - m_c2);
        rd(5'd2, 32'(m_c1), {t, "_count1"});
        rd(5'd3, 32'(m_c2), {t, "_count2"});
        rd(5'd4, xv, {t, "_x"});
        rd(5'd5, sq33[31:0], {t, "_sumsq_lo"});
        rd(5'd6, {31'b0, sq33[32]}, {t, "_sumsq_hi"});
        rd(5'd7, 32'(isqrt(sq)), {t, "_result"});
        rd(5'd10, 32'(samples_exp), {t, "_samples"});
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int d1[4] = '{400, 900, 1500, 2150};
        int d2[4] = '{400, 900, 1470, 2100};
        int base, b, w;
        longint p1, p2;

        // Reset state
        do_reset();
        check("readdata_no_read", slave_readdata, 32'h0);
        rd(5'd0, 32'h1, "ctrl_reset");
        rd(5'd1, 32'h0, "status_reset");
        rd(5'd2, 32'h0, "count1_reset");
        check("gpio_outputs_reset", gpio_outputs, 32'h0);
        tick();
        check("readdata_after_read", slave_readdata, 32'h0);

        // 3000 / 4000 interval pair with exact done latency
        trip_at(3000, 1'b1, 1'b0);
        trip_at(4000, 1'b0, 1'b1);
        wait_until(4019);
        rd(5'd1, 32'h2, "status_busy_before_done");
        rd(5'd1, 32'h1, "status_done_at_19");
        samples_exp++;
        read_results("t3000");
        check("x_is_minus_1000", 32'(m_c1 - m_c2), 32'hFFFFFC18);
        wr(5'd1, 32'h1, 4'hF);
        rd(5'd1, 32'h0, "status_done_cleared");

        // Repeated pairs, simultaneous and staggered in both orders
        base = edge_n + 10;
        for (int k = 0; k < 4; k++) begin
            if (d1[k] == d2[k]) begin
                trip_at(base + d1[k], 1'b1, 1'b1);
            end else if (d1[k] < d2[k]) begin
                trip_at(base + d1[k], 1'b1, 1'b0);
                trip_at(base + d2[k], 1'b0, 1'b1);
            end else begin
                trip_at(base + d2[k], 1'b0, 1'b1);
                trip_at(base + d1[k], 1'b1, 1'b0);
            end
            wait_done();
            read_results($sformatf("pair%0d", k));
            wr(5'd1, 32'h1, 4'hF);
        end

        // Event during busy still latches; CTRL.clear wipes valids and done
        b = edge_n + 300;
        trip_at(b, 1'b1, 1'b1);
        p1 = m_c1;
        p2 = m_c2;
        trip_at(b + 6, 1'b1, 1'b0);
        wait_done();
        rd(5'd1, 32'h5, "status_busy_event");
        rd(5'd2, 32'(m_c1), "count1_busy_event");
        rd(5'd7, 32'(isqrt(p1 * p1 + p2 * p2)), "result_busy_event");
        wr(5'd0, 32'h3, 4'hF);
        last1 = edge_n;
        last2 = edge_n;
        rd(5'd1, 32'h0, "status_after_clear");
        rd(5'd0, 32'h1, "ctrl_after_clear");

        // GPIO
        wr(5'd8, 32'hAABBCCDD, 4'b0101);
        rd(5'd8, 32'h00BB00DD, "gpio_out_byteenable");
        check("gpio_outputs_pin", gpio_outputs, 32'h00BB00DD);
        gpio_inputs = 32'h12345678;
        tick();
        rd(5'd9, 32'h12345678, "gpio_in");

        // Saturation and overflow flags
        w = last1;
        wait_until(w + 65534);
        rd(5'd1, 32'h0, "status_before_ovf");
        rd(5'd1, 32'h30, "status_ovf");
        wr(5'd1, 32'h30, 4'hF);
        rd(5'd1, 32'h0, "status_ovf_cleared");
        trip_at(edge_n + 20, 1'b1, 1'b1);
        wait_done();
        read_results("saturated");
        wr(5'd1, 32'h1, 4'hF);

        // Reset during the square-root phase aborts and clears results
        b = edge_n + 50;
        trip_at(b, 1'b1, 1'b1);
        wait_until(b + 9);
        do_reset();
        rd(5'd1, 32'h0, "status_after_abort");
        rd(5'd7, 32'h0, "result_after_abort");
        rd(5'd4, 32'h0, "x_after_abort");
        rd(5'd10, 32'h0, "samples_after_abort");
        check("gpio_outputs_after_abort", gpio_outputs, 32'h0);
        trip_at(300, 1'b1, 1'b0);
        trip_at(420, 1'b0, 1'b1);
        wait_done();
        read_results("post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
